traffic_light_monitor: RTL and testbench

Passive protocol checker on the six lamp outputs of the traffic light controller: ns_g/ns_y/ns_r and ew_g/ew_y/ew_r.
- Tracks the NS/EW phase sequence and times each phase.
- Flags the first safety or timing violation and holds it until reset.
- Counts completed full signal cycles.
- Sits beside the controller in simulation and on-chip self-check. It drives nothing back into the controller.

---
 rtl/traffic_light_monitor.sv | 203 ++++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker for a two-direction traffic light.
// Tracks the NS/EW phase sequence, times every phase, latches the first
// safety/timing violation until reset and counts completed NS-to-NS cycles.
// Optional feature macro: TLM_ALLRED_EN (allows a short all-red gap after
// either yellow before the opposite green).
module traffic_light_monitor #(
  parameter int GREEN_MIN  = 4,
  parameter int GREEN_MAX  = 16,
  parameter int YELLOW_CYC = 2,
  parameter int ALLRED_MAX = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ns_g,
  input  logic             ns_y,
  input  logic             ns_r,
  input  logic             ew_g,
  input  logic             ew_y,
  input  logic             ew_r,
  output logic             sync,
  output logic [2:0]       phase,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [2:0] {
    ST_SYNC   = 3'd0,
    ST_NSG    = 3'd1,
    ST_NSY    = 3'd2,
    ST_EWG    = 3'd3,
    ST_EWY    = 3'd4,
    ST_ALLRED = 3'd5,
    ST_FAULT  = 3'd7
  } phase_t;

  // Decoded lamp pattern; PAT_BAD means a direction without exactly one lamp.
  typedef enum logic [2:0] {
    PAT_BAD, PAT_NSG, PAT_NSY, PAT_EWG, PAT_EWY, PAT_AR, PAT_CONFLICT
  } pat_t;

  localparam logic [CNT_W-1:0] G_MIN  = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] G_MAX  = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] Y_CYC  = CNT_W'(YELLOW_CYC);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  phase_t           state, state_nx;
  pat_t             pat;
  logic [CNT_W-1:0] dur, dur_nx, cyc_nx;
  logic             sync_nx;
  logic [2:0]       code;
  logic             ns_ok, ew_ok;

`ifdef TLM_ALLRED_EN
  localparam logic [CNT_W-1:0] AR_MAX = CNT_W'(ALLRED_MAX);
  // Remembers which yellow led into ALLRED, selecting the required next green.
  logic ar_ns, ar_ns_nx;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  // A case match never succeeds on X/Z bits, so unknown lamps decode as bad.
  function automatic logic one_lamp(input logic [2:0] l);
    logic ok;
    case (l)
      3'b001, 3'b010, 3'b100: ok = 1'b1;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign ns_ok = one_lamp({ns_g, ns_y, ns_r});
  assign ew_ok = one_lamp({ew_g, ew_y, ew_r});
  assign phase = state;

  // Classify the sampled lamps into one legal pattern, a conflict or bad.
  always_comb begin
    pat = PAT_BAD;
    if (ns_ok && ew_ok) begin
      if (ns_r && ew_r)  pat = PAT_AR;
      else if (ew_r)     pat = ns_g ? PAT_NSG : PAT_NSY;
      else if (ns_r)     pat = ew_g ? PAT_EWG : PAT_EWY;
      else               pat = PAT_CONFLICT;
    end
  end

  // Next phase, duration, cycle count and lowest-numbered violation code.
  always_comb begin
    state_nx = state;
    dur_nx   = dur;
    cyc_nx   = cycles;
    sync_nx  = sync;
    code     = 3'd0;
`ifdef TLM_ALLRED_EN
    ar_ns_nx = ar_ns;
`endif
    if (state != ST_FAULT) begin
      if (pat == PAT_BAD)           code = 3'd1;
      else if (pat == PAT_CONFLICT) code = 3'd2;
      else begin
        case (state)
          ST_SYNC: begin
            if (pat == PAT_NSG || pat == PAT_EWG) begin
              state_nx = (pat == PAT_NSG) ? ST_NSG : ST_EWG;
              dur_nx   = ONE;
              sync_nx  = 1'b1;
            end
          end
          ST_NSG, ST_EWG: begin
            if (pat == ((state == ST_NSG) ? PAT_NSG : PAT_EWG)) begin
              // dur already equals GREEN_MAX: this is one sample too many.
              if (dur >= G_MAX) code = 3'd5;
              else              dur_nx = sat_inc(dur);
            end else if (pat == ((state == ST_NSG) ? PAT_NSY : PAT_EWY)) begin
              if (dur < G_MIN) code = 3'd4;
              else begin
                state_nx = (state == ST_NSG) ? ST_NSY : ST_EWY;
                dur_nx   = ONE;
              end
            end else if (pat == PAT_AR) begin
              code = (dur < G_MIN) ? 3'd4 : 3'd7;
            end else begin
              code = 3'd3;
            end
          end
          ST_NSY, ST_EWY: begin
            if (pat == ((state == ST_NSY) ? PAT_NSY : PAT_EWY)) begin
              if (dur >= Y_CYC) code = 3'd6;
              else              dur_nx = sat_inc(dur);
            end else if (pat == ((state == ST_NSY) ? PAT_EWG : PAT_NSG)) begin
              if (dur != Y_CYC) code = 3'd6;
              else begin
                state_nx = (state == ST_NSY) ? ST_EWG : ST_NSG;
                dur_nx   = ONE;
                if (state == ST_EWY) cyc_nx = sat_inc(cycles);
              end
            end else if (pat == PAT_AR) begin
              if (dur != Y_CYC) code = 3'd6;
`ifdef TLM_ALLRED_EN
              else begin
                state_nx = ST_ALLRED;
                dur_nx   = ONE;
                ar_ns_nx = (state == ST_NSY);
              end
`else
              else code = 3'd7;
`endif
            end else begin
              code = 3'd3;
            end
          end
`ifdef TLM_ALLRED_EN
          ST_ALLRED: begin
            if (pat == PAT_AR) begin
              if (dur >= AR_MAX) code = 3'd7;
              else               dur_nx = sat_inc(dur);
            end else if (pat == (ar_ns ? PAT_EWG : PAT_NSG)) begin
              state_nx = ar_ns ? ST_EWG : ST_NSG;
              dur_nx   = ONE;
              if (!ar_ns) cyc_nx = sat_inc(cycles);
            end else begin
              code = 3'd3;
            end
          end
`endif
          default: ;
        endcase
      end
      if (code != 3'd0) state_nx = ST_FAULT;
    end
  end

  // Registered state and outputs; the first violation code is latched for good.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_SYNC;
      dur      <= '0;
      cycles   <= '0;
      sync     <= 1'b0;
      err      <= 1'b0;
      err_code <= 3'd0;
`ifdef TLM_ALLRED_EN
      ar_ns    <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      dur    <= dur_nx;
      cycles <= cyc_nx;
      sync   <= sync_nx;
`ifdef TLM_ALLRED_EN
      ar_ns  <= ar_ns_nx;
`endif
      if (code != 3'd0) begin
        err      <= 1'b1;
        err_code <= code;
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed testbench for traffic_light_monitor with hand-computed expectations.
module tb_traffic_light_monitor;

  localparam int CNT_W = 8;

  // Lamp vectors: {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}
  localparam logic [5:0] NSG  = 6'b100_001;
  localparam logic [5:0] NSY  = 6'b010_001;
  localparam logic [5:0] EWG  = 6'b001_100;
  localparam logic [5:0] EWY  = 6'b001_010;
  localparam logic [5:0] AR   = 6'b001_001;
  localparam logic [5:0] CONF = 6'b100_100;
  localparam logic [5:0] NSGY = 6'b110_001;

  logic             clk = 1'b0;
  logic             rst;
  logic [5:0]       lamps;
  logic             ns_g, ns_y, ns_r, ew_g, ew_y, ew_r;
  logic             sync, err;
  logic [2:0]       phase, err_code;
  logic [CNT_W-1:0] cycles;

  int checks   = 0;
  int failures = 0;

  assign {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = lamps;

  traffic_light_monitor #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r),
    .ew_g(ew_g), .ew_y(ew_y), .ew_r(ew_r),
    .sync(sync), .phase(phase), .err(err), .err_code(err_code), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Hold a lamp pattern for n rising edges; returns 1 time unit after the last.
  task automatic apply(input logic [5:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      lamps = pat;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst   = 1'b0;
    lamps = AR;
    #12;
    check("rst_sync", sync, 0);
    check("rst_phase", phase, 0);
    check("rst_err", err, 0);
    check("rst_code", err_code, 0);
    check("rst_cycles", cycles, 0);
    rst = 1'b1;

    // Legal loop with default timing, three full cycles.
    for (int i = 0; i < 3; i++) begin
      apply(NSG, 6);
      if (i == 0) check("loop_sync", sync, 1);
      check("loop_cyc", cycles, i);
      check("loop_ph_nsg", phase, 1);
      apply(NSY, 2);
      check("loop_ph_nsy", phase, 2);
      apply(EWG, 6);
      check("loop_ph_ewg", phase, 3);
      apply(EWY, 2);
      check("loop_ph_ewy", phase, 4);
    end
    apply(NSG, 1);
    check("loop_cycles3", cycles, 3);
    check("loop_ph_end", phase, 1);
    check("loop_err", err, 0);

    // Conflict during green, then legal input must not change the code.
    apply(NSG, 1);
    apply(CONF, 1);
    check("conf_err", err, 1);
    check("conf_code", err_code, 2);
    check("conf_phase", phase, 7);
    apply(NSG, 2);
    check("conf_hold_code", err_code, 2);
    check("conf_hold_phase", phase, 7);

    // Short green.
    pulse_reset();
    apply(NSG, 3);
    check("short_pre_err", err, 0);
    apply(NSY, 1);
    check("short_code", err_code, 4);

    // Boundary greens of exactly GREEN_MIN and GREEN_MAX.
    pulse_reset();
    apply(NSG, 4);
    apply(NSY, 2);
    apply(EWG, 16);
    apply(EWY, 2);
    apply(NSG, 1);
    check("bound_err", err, 0);
    check("bound_cycles", cycles, 1);
    check("bound_phase", phase, 1);

    // Green held for GREEN_MAX+1 samples.
    pulse_reset();
    apply(NSG, 16);
    check("gmax_pre_err", err, 0);
    apply(NSG, 1);
    check("gmax_code", err_code, 5);

    // Yellow held one cycle too long.
    pulse_reset();
    apply(NSG, 4);
    apply(NSY, 2);
    check("ylong_pre_err", err, 0);
    apply(NSY, 1);
    check("ylong_code", err_code, 6);

    // Yellow back to its own green.
    pulse_reset();
    apply(NSG, 4);
    apply(NSY, 1);
    apply(NSG, 1);
    check("illegal_tr_code", err_code, 3);

    // Two lamps on in one direction.
    pulse_reset();
    apply(NSG, 4);
    apply(NSGY, 1);
    check("two_lamp_code", err_code, 1);
    check("two_lamp_phase", phase, 7);

    // Asynchronous reset mid-EWG, then resync only on the next green.
    pulse_reset();
    apply(NSG, 4);
    apply(NSY, 2);
    apply(EWG, 3);
    check("mid_pre_phase", phase, 3);
    check("mid_pre_err", err, 0);
    rst = 1'b0;
    #1;
    check("mid_rst_sync", sync, 0);
    check("mid_rst_phase", phase, 0);
    check("mid_rst_err", err, 0);
    lamps = EWY;
    #2;
    rst = 1'b1;
    apply(EWY, 3);
    check("resync_wait_phase", phase, 0);
    check("resync_wait_sync", sync, 0);
    check("resync_wait_err", err, 0);
    apply(EWG, 1);
    check("resync_phase", phase, 3);
    check("resync_sync", sync, 1);

    // All-red handling.
    pulse_reset();
    apply(NSG, 4);
    apply(NSY, 2);
`ifdef TLM_ALLRED_EN
    apply(AR, 2);
    check("ar_phase", phase, 5);
    apply(EWG, 1);
    check("ar_ok_err", err, 0);
    check("ar_ok_phase", phase, 3);
    pulse_reset();
    apply(NSG, 4);
    apply(NSY, 2);
    apply(AR, 2);
    check("ar_pre_err", err, 0);
    apply(AR, 1);
    check("ar_long_code", err_code, 7);
`else
    apply(AR, 1);
    check("ar_off_code", err_code, 7);
    check("ar_off_phase", phase, 7);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
